// File: rtl/mc_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response,
// core-side instruction handshake and branch redirect.
interface mc_fetch_unit_if #(
   parameter int PC_WIDTH    = 16,
   parameter int INSTR_WIDTH = 32
);
   logic                   mem_req_valid;
   logic                   mem_req_ready;
   logic [PC_WIDTH-1:0]    mem_req_addr;
   logic                   mem_rsp_valid;
   logic [INSTR_WIDTH-1:0] mem_rsp_data;
   logic                   instr_valid;
   logic                   instr_ready;
   logic [INSTR_WIDTH-1:0] instr;
   logic [PC_WIDTH-1:0]    instr_pc;
   logic                   redirect_valid;
   logic [PC_WIDTH-1:0]    redirect_pc;

   modport master (
      output mem_req_valid,
      output mem_req_addr,
      input  mem_req_ready,
      input  mem_rsp_valid,
      input  mem_rsp_data,
      output instr_valid,
      output instr,
      output instr_pc,
      input  instr_ready,
      input  redirect_valid,
      input  redirect_pc
   );

   modport slave (
      input  mem_req_valid,
      input  mem_req_addr,
      output mem_req_ready,
      output mem_rsp_valid,
      output mem_rsp_data,
      input  instr_valid,
      input  instr,
      input  instr_pc,
      output instr_ready,
      output redirect_valid,
      output redirect_pc
   );
endinterface

// File: rtl/mc_fetch_unit.sv
// Instruction fetch stage: PC, capped request issue, prefetch FIFO
// with PC tags, and redirect flush with stale-response discard.
module mc_fetch_unit #(
   parameter int                  PC_WIDTH    = 16,
   parameter int                  INSTR_WIDTH = 32,
   parameter int                  DEPTH       = 2,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
   input logic             clk,
   input logic             reset,
   mc_fetch_unit_if.master bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SW = CW + 2;

   logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [CW-1:0]          out_q, out_d;
   logic [CW-1:0]          disc_q, disc_d;
   logic [AW-1:0]          wr_q, wr_d;
   logic [AW-1:0]          rd_q, rd_d;
   logic [AW-1:0]          tag_wr_q, tag_wr_d;
   logic [AW-1:0]          tag_rd_q, tag_rd_d;
   logic [INSTR_WIDTH-1:0] hold_instr_q, hold_instr_d;
   logic [PC_WIDTH-1:0]    hold_pc_q, hold_pc_d;

   logic [INSTR_WIDTH-1:0] data_q [DEPTH];
   logic [PC_WIDTH-1:0]    pc_q   [DEPTH];
   logic [PC_WIDTH-1:0]    tag_q  [DEPTH];

   logic [SW-1:0]          load;
   logic                   empty;
   logic                   req_fire;
   logic                   rsp_in;
   logic                   rsp_keep;
   logic                   push;
   logic                   pop;
   logic                   redir;
   logic [INSTR_WIDTH-1:0] head_instr;
   logic [PC_WIDTH-1:0]    head_pc;

   function automatic logic [AW-1:0] ptr_inc(
      input logic [AW-1:0] p
   );
      if (p == AW'(DEPTH - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   assign redir = bus.redirect_valid && !reset;

   // Buffered + in flight + still-to-drop never exceeds DEPTH
   assign load = SW'(cnt_q) + SW'(out_q)
               + SW'(disc_q);

   assign bus.mem_req_valid = !reset
                           && !bus.redirect_valid
                           && (load < SW'(DEPTH));
   assign bus.mem_req_addr  = reset ? RESET_PC
                                    : fetch_pc_q;

   assign empty      = (cnt_q == '0);
   assign head_instr = data_q[rd_q];
   assign head_pc    = pc_q[rd_q];

   assign bus.instr_valid = !reset && !empty;
   assign bus.instr    = reset ? '0
                       : (empty ? hold_instr_q
                                : head_instr);
   assign bus.instr_pc = reset ? '0
                       : (empty ? hold_pc_q
                                : head_pc);

   assign req_fire = bus.mem_req_valid
                  && bus.mem_req_ready;
   assign rsp_in   = !reset && bus.mem_rsp_valid;
   assign rsp_keep = rsp_in && (disc_q == '0);
   assign push     = rsp_keep && !redir;
   assign pop      = bus.instr_valid
                  && bus.instr_ready;

   // Next-state for PC, counters, FIFO pointers and held outputs
   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      cnt_d        = cnt_q;
      out_d        = out_q;
      disc_d       = disc_q;
      wr_d         = wr_q;
      rd_d         = rd_q;
      tag_wr_d     = tag_wr_q;
      tag_rd_d     = tag_rd_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;

      if (!empty) begin
         hold_instr_d = head_instr;
         hold_pc_d    = head_pc;
      end

      if (req_fire) begin
         fetch_pc_d = fetch_pc_q + 1'b1;
         tag_wr_d   = ptr_inc(tag_wr_q);
      end

      if (rsp_keep) begin
         tag_rd_d = ptr_inc(tag_rd_q);
      end

      if (rsp_in && (disc_q != '0)) begin
         disc_d = disc_q - 1'b1;
      end

      out_d = out_q + CW'(req_fire)
                    - CW'(rsp_keep);

      if (push) begin
         wr_d = ptr_inc(wr_q);
      end
      if (pop) begin
         rd_d = ptr_inc(rd_q);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);

      if (redir) begin
         // Every in-flight response becomes stale;
         // one arriving now is consumed right here.
         fetch_pc_d = bus.redirect_pc;
         disc_d     = disc_q + out_q
                    - CW'(rsp_in);
         out_d      = '0;
         cnt_d      = '0;
         wr_d       = '0;
         rd_d       = '0;
         tag_wr_d   = '0;
         tag_rd_d   = '0;
      end
   end

   // Control state register with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q   <= RESET_PC;
         cnt_q        <= '0;
         out_q        <= '0;
         disc_q       <= '0;
         wr_q         <= '0;
         rd_q         <= '0;
         tag_wr_q     <= '0;
         tag_rd_q     <= '0;
         hold_instr_q <= '0;
         hold_pc_q    <= '0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         cnt_q        <= cnt_d;
         out_q        <= out_d;
         disc_q       <= disc_d;
         wr_q         <= wr_d;
         rd_q         <= rd_d;
         tag_wr_q     <= tag_wr_d;
         tag_rd_q     <= tag_rd_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
      end
   end

   // Prefetch data and PC tag storage; contents need no reset
   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_q] <= bus.mem_rsp_data;
         pc_q[wr_q]   <= tag_q[tag_rd_q];
      end
      if (req_fire) begin
         tag_q[tag_wr_q] <= fetch_pc_q;
      end
   end

   // A response needs a slot: something to drop or an owed request
   a_rsp_legal: assert property (
      @(posedge clk) disable iff (reset)
      bus.mem_rsp_valid |->
         (disc_q != '0)
         || ((out_q != '0)
             && (cnt_q < CW'(DEPTH)))
   );
endmodule

// File: tb/tb_mc_fetch_unit.sv
// Scoreboard bench for mc_fetch_unit: directed phases push the
// expected PC stream; a monitor checks every instruction handshake.
module tb_mc_fetch_unit;
   localparam int PW = 16;
   localparam int IW = 32;

   typedef struct {
      logic [PW-1:0] addr;
      int            due;
   } req_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int n_chk = 0;
   int n_fail = 0;
   int lat = 1;
   int cyc = 0;
   int n_acc = 0;

   logic [PW-1:0] exp_q[$];
   req_t          pipe[$];

   always #5 clk = ~clk;

   mc_fetch_unit_if #(
      .PC_WIDTH(PW),
      .INSTR_WIDTH(IW)
   ) bus ();

   mc_fetch_unit #(
      .PC_WIDTH(PW),
      .INSTR_WIDTH(IW),
      .DEPTH(2),
      .RESET_PC(16'h0000)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   function automatic logic [IW-1:0] word_of(
      input logic [PW-1:0] a
   );
      return 32'h100 + IW'(a);
   endfunction

   task automatic check(
      input string       name,
      input logic [31:0] act,
      input logic [31:0] exp
   );
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h",
                  name, act, exp);
      end
   endtask

   // Memory: fixed latency, data = 0x100 + addr,
   // reset together with the fetch unit
   always @(negedge clk) begin
      req_t r;
      cyc++;
      if (reset) begin
         pipe.delete();
         bus.mem_rsp_valid = 1'b0;
         bus.mem_rsp_data  = '0;
      end else begin
         bus.mem_rsp_valid = 1'b0;
         if (pipe.size() != 0
             && pipe[0].due <= cyc) begin
            r = pipe.pop_front();
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = word_of(r.addr);
         end
         if (bus.mem_req_valid === 1'b1
             && bus.mem_req_ready === 1'b1) begin
            r.addr = bus.mem_req_addr;
            r.due  = cyc + lat;
            pipe.push_back(r);
            n_acc++;
         end
      end
   end

   // Monitor: every delivered instruction must be the next expected
   always @(negedge clk) begin
      logic [PW-1:0] e;
      if (bus.instr_valid === 1'b1
          && bus.instr_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_instr: got pc %0h, expected none",
                     bus.instr_pc);
         end else begin
            e = exp_q.pop_front();
            check("instr_pc", 32'(bus.instr_pc), 32'(e));
            check("instr", bus.instr, word_of(e));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.instr_ready    = 1'b0;
      repeat (n) tick();
      reset = 1'b0;
   endtask

   task automatic drain(
      input string name,
      input int    budget
   );
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      #1;
      bus.instr_ready = 1'b0;
      check(name, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc0;
      bus.mem_req_ready  = 1'b1;
      bus.instr_ready    = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;

      // Reset state and sequential stream, latency 1
      lat = 1;
      reset = 1'b1;
      tick();
      tick();
      sample();
      check("rst_instr_valid", 32'(bus.instr_valid), 0);
      check("rst_req_valid", 32'(bus.mem_req_valid), 0);
      check("rst_req_addr", 32'(bus.mem_req_addr), 0);
      check("rst_instr", bus.instr, 0);
      check("rst_instr_pc", 32'(bus.instr_pc), 0);
      tick();
      bus.instr_ready = 1'b1;
      for (int i = 0; i < 6; i++) exp_q.push_back(PW'(i));
      reset = 1'b0;
      sample();
      check("first_req_valid", 32'(bus.mem_req_valid), 1);
      check("first_req_addr", 32'(bus.mem_req_addr), 0);
      check("first_instr_valid", 32'(bus.instr_valid), 0);
      tick();
      drain("drain_seq", 100);

      // Core stalled: cap stops issue after two requests
      tick();
      do_reset(2);
      lat  = 1;
      acc0 = n_acc;
      repeat (6) tick();
      sample();
      check("stall_accepts", 32'(n_acc - acc0), 2);
      check("stall_req_valid", 32'(bus.mem_req_valid), 0);
      check("stall_instr_valid", 32'(bus.instr_valid), 1);
      check("stall_instr", bus.instr, 32'h100);
      check("stall_instr_pc", 32'(bus.instr_pc), 0);
      repeat (3) tick();
      sample();
      check("stall_hold_instr", bus.instr, 32'h100);
      check("stall_hold_pc", 32'(bus.instr_pc), 0);
      check("stall_hold_req", 32'(bus.mem_req_valid), 0);
      tick();
      for (int i = 0; i < 4; i++) exp_q.push_back(PW'(i));
      bus.instr_ready = 1'b1;
      drain("drain_stall", 100);

      // Redirect with two requests in flight, latency 3
      tick();
      do_reset(2);
      lat = 3;
      bus.instr_ready = 1'b1;
      exp_q.push_back(16'h0040);
      exp_q.push_back(16'h0041);
      exp_q.push_back(16'h0042);
      tick();
      tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 16'h0040;
      sample();
      check("redir_no_req", 32'(bus.mem_req_valid), 0);
      tick();
      bus.redirect_valid = 1'b0;
      sample();
      check("redir_disc_cap", 32'(bus.mem_req_valid), 0);
      tick();
      sample();
      check("redir_req_valid", 32'(bus.mem_req_valid), 1);
      check("redir_req_addr", 32'(bus.mem_req_addr), 32'h40);
      tick();
      drain("drain_redir", 100);

      // Redirect coinciding with handshake of pc 5 and rsp for pc 6
      tick();
      do_reset(2);
      lat = 2;
      bus.instr_ready    = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 16'h0001;
      for (int i = 1; i <= 5; i++) exp_q.push_back(PW'(i));
      exp_q.push_back(16'h0080);
      exp_q.push_back(16'h0081);
      tick();
      bus.redirect_valid = 1'b0;
      repeat (11) tick();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 16'h0080;
      sample();
      check("coinc_instr_valid", 32'(bus.instr_valid), 1);
      check("coinc_instr_pc", 32'(bus.instr_pc), 5);
      tick();
      bus.redirect_valid = 1'b0;
      drain("drain_coinc", 100);

      // PC wrap across 0xFFFF
      tick();
      do_reset(2);
      lat = 1;
      bus.instr_ready    = 1'b1;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 16'hFFFE;
      exp_q.push_back(16'hFFFE);
      exp_q.push_back(16'hFFFF);
      exp_q.push_back(16'h0000);
      exp_q.push_back(16'h0001);
      tick();
      bus.redirect_valid = 1'b0;
      drain("drain_wrap", 100);

      // Reset mid-stream with FIFO occupied and a request in flight
      tick();
      do_reset(2);
      lat = 3;
      repeat (4) tick();
      sample();
      check("mid_instr_valid", 32'(bus.instr_valid), 1);
      check("mid_instr_pc", 32'(bus.instr_pc), 0);
      check("mid_req_valid", 32'(bus.mem_req_valid), 0);
      reset = 1'b1;
      tick();
      sample();
      check("mid_rst_instr_valid", 32'(bus.instr_valid), 0);
      check("mid_rst_req_valid", 32'(bus.mem_req_valid), 0);
      tick();
      reset = 1'b0;
      bus.instr_ready = 1'b1;
      exp_q.push_back(16'h0000);
      exp_q.push_back(16'h0001);
      sample();
      check("post_rst_req_valid", 32'(bus.mem_req_valid), 1);
      check("post_rst_req_addr", 32'(bus.mem_req_addr), 0);
      check("post_rst_instr_valid", 32'(bus.instr_valid), 0);
      tick();
      drain("drain_post_rst", 100);

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
